relu_backprop: RTL and testbench

- Backward-pass counterpart of the forward ReLU activation stage.
- During the forward pass it captures one derivative mask bit per activation input.
- During the backward pass it gates the incoming gradient stream with those bits: pass where the forward input was non-negative, zero where it was negative.
- Sits between the layer's activation stage and the gradient path to the preceding layer's weight-update logic.

---
 rtl/relu_backprop.sv | 136 +++++++++++++
 tb/tb_relu_backprop.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_backprop.sv
// ReLU backward stage: captures sign masks during the forward pass and
// uses them to gate the gradient stream during the backward pass.
module relu_backprop #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W:0]       len,
    input  logic                  fwd_valid,
    input  logic [DATA_WIDTH-1:0] fwd_data,
    input  logic                  grad_valid,
    output logic                  grad_ready,
    input  logic [DATA_WIDTH-1:0] grad_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        BACKWARD
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t state, state_n;

    logic [ADDR_W:0]       len_q, len_n;
    logic [ADDR_W:0]       wr_ptr, wr_n;
    logic [ADDR_W:0]       rd_ptr, rd_n;
    logic                  valid_n, done_n, err_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  mask [DEPTH];
    logic                  wr_en, grad_fire, out_fire;

    assign busy       = (state != IDLE);
    assign wr_en      = (state == CAPTURE) && fwd_valid;
    assign grad_ready = (state == BACKWARD) && (!out_valid || out_ready)
                        && (rd_ptr < len_q);
    assign grad_fire  = grad_valid && grad_ready;
    assign out_fire   = out_valid && out_ready;

    // Mask storage needs no reset; every entry read is written first.
    always_ff @(posedge clk) begin
        if (wr_en)
            mask[wr_ptr[ADDR_W-1:0]] <= ~fwd_data[DATA_WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            len_q     <= len_n;
            wr_ptr    <= wr_n;
            rd_ptr    <= rd_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        len_n   = len_q;
        wr_n    = wr_ptr;
        rd_n    = rd_ptr;
        valid_n = out_valid;
        data_n  = out_data;
        done_n  = 1'b0;
        err_n   = err;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_n = 1'b1;
                    end else if (len > MAX_LEN) begin
                        err_n = 1'b1;
                    end else begin
                        len_n   = len;
                        wr_n    = '0;
                        rd_n    = '0;
                        err_n   = 1'b0;
                        state_n = CAPTURE;
                    end
                end
                if (fwd_valid)
                    err_n = 1'b1;
            end
            CAPTURE: begin
                if (start)
                    err_n = 1'b1;
                if (fwd_valid) begin
                    wr_n = wr_ptr + ONE;
                    if (wr_ptr + ONE == len_q)
                        state_n = BACKWARD;
                end
            end
            BACKWARD: begin
                if (start || fwd_valid)
                    err_n = 1'b1;
                if (grad_fire) begin
                    valid_n = 1'b1;
                    data_n  = mask[rd_ptr[ADDR_W-1:0]] ? grad_data : '0;
                    rd_n    = rd_ptr + ONE;
                end else if (out_fire) begin
                    valid_n = 1'b0;
                end
                // Final beat leaves: busy drops together with done
                if (out_fire && rd_ptr == len_q) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_relu_backprop.sv
// Directed self-checking bench for relu_backprop.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_relu_backprop;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  len;
    logic        fwd_valid;
    logic [15:0] fwd_data;
    logic        grad_valid;
    logic        grad_ready;
    logic [15:0] grad_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] fwd_v  [256];
    logic [15:0] grad_v [256];
    logic [15:0] exp_v  [256];

    relu_backprop dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .fwd_valid  (fwd_valid),
        .fwd_data   (fwd_data),
        .grad_valid (grad_valid),
        .grad_ready (grad_ready),
        .grad_data  (grad_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input int n);
        start = 1'b1;
        len   = 9'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            fwd_valid = 1'b1;
            fwd_data  = fwd_v[i];
            tick();
        end
        fwd_valid = 1'b0;
        fwd_data  = '0;
    endtask

    // Streams grads gi0..n-1 with out_ready high; returns in the done cycle.
    task automatic run_back(input int n, input int gi0, input string tag,
                            input bit timing);
        int gi = gi0;
        int oi = 0;
        int cyc = 0;
        int first_hs = -1;
        int first_out = -1;
        int last_out = -1;
        bit got_done = 1'b0;
        bit hs;
        out_ready = 1'b1;
        while (!got_done && cyc < 2000) begin
            grad_valid = (gi < n);
            grad_data  = (gi < n) ? grad_v[gi] : 16'h0;
            #1;
            if (out_valid && out_ready) begin
                if (oi < n)
                    check({tag, "_out"}, out_data, exp_v[oi]);
                if (first_out < 0)
                    first_out = cyc;
                last_out = cyc;
                oi++;
            end
            hs = grad_valid && grad_ready;
            if (hs && first_hs < 0)
                first_hs = cyc;
            if (hs)
                gi++;
            tick();
            cyc++;
            if (done)
                got_done = 1'b1;
        end
        grad_valid = 1'b0;
        grad_data  = '0;
        check({tag, "_done"}, got_done, 1'b1);
        check({tag, "_count"}, oi, n);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_oval"}, out_valid, 1'b0);
        if (timing) begin
            check({tag, "_lat"}, first_out, first_hs + 1);
            check({tag, "_span"}, last_out - first_out, n - 1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        len        = '0;
        fwd_valid  = 1'b0;
        fwd_data   = '0;
        grad_valid = 1'b0;
        grad_data  = '0;
        out_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_oval", out_valid, 1'b0);
        check("rst_odata", out_data, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_gready", grad_ready, 1'b0);

        // basic gating
        fwd_v[0] = 16'h0005; fwd_v[1] = 16'hFFFD;
        fwd_v[2] = 16'h0000; fwd_v[3] = 16'h8000;
        grad_v[0] = 16'h0064; grad_v[1] = 16'h00C8;
        grad_v[2] = 16'hFFF9; grad_v[3] = 16'h0009;
        exp_v[0] = 16'h0064; exp_v[1] = 16'h0000;
        exp_v[2] = 16'hFFF9; exp_v[3] = 16'h0000;
        start_seq(4);
        check("t1_busy", busy, 1'b1);
        capture(4);
        check("t1_gready_cap", grad_ready, 1'b1);
        run_back(4, 0, "t1", 1'b1);
        check("t1_err", err, 1'b0);
        tick();
        check("t1_done_pulse", done, 1'b0);

        // backpressure
        fwd_v[0] = 16'h0001; fwd_v[1] = 16'h0002; fwd_v[2] = 16'h0003;
        grad_v[0] = 16'h1111; grad_v[1] = 16'h2222; grad_v[2] = 16'h3333;
        exp_v[0] = 16'h1111; exp_v[1] = 16'h2222; exp_v[2] = 16'h3333;
        start_seq(3);
        fwd_valid = 1'b1;
        fwd_data  = fwd_v[0];
        #1;
        check("t2_gready_cap", grad_ready, 1'b0);
        tick();
        fwd_data = fwd_v[1];
        tick();
        fwd_data = fwd_v[2];
        tick();
        fwd_valid = 1'b0;
        out_ready  = 1'b0;
        grad_valid = 1'b1;
        grad_data  = grad_v[0];
        #1;
        check("t2_gready0", grad_ready, 1'b1);
        tick();
        grad_data = grad_v[1];
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_stall_gready", grad_ready, 1'b0);
            check("t2_stall_oval", out_valid, 1'b1);
            check("t2_stall_odata", out_data, 16'h1111);
            tick();
        end
        run_back(3, 1, "t2", 1'b0);

        // full depth, then back-to-back
        for (int i = 0; i < 256; i++) begin
            fwd_v[i]  = (i % 2 == 0) ? 16'(i) : 16'(-i);
            grad_v[i] = 16'(i * 37 + 1);
            exp_v[i]  = (i % 2 == 0) ? 16'(i * 37 + 1) : 16'h0;
        end
        start_seq(256);
        capture(256);
        run_back(256, 0, "t3a", 1'b1);
        fwd_v[0] = 16'hFFFF; fwd_v[1] = 16'h0001;
        fwd_v[2] = 16'hFFFF; fwd_v[3] = 16'h0001;
        grad_v[0] = 16'hA001; grad_v[1] = 16'hA002;
        grad_v[2] = 16'hA003; grad_v[3] = 16'hA004;
        exp_v[0] = 16'h0000; exp_v[1] = 16'hA002;
        exp_v[2] = 16'h0000; exp_v[3] = 16'hA004;
        start_seq(4);
        check("t3b_busy", busy, 1'b1);
        check("t3b_err", err, 1'b0);
        capture(4);
        run_back(4, 0, "t3b", 1'b1);
        tick();

        // length boundaries
        start_seq(0);
        check("t4_len0_done", done, 1'b1);
        check("t4_len0_busy", busy, 1'b0);
        check("t4_len0_err", err, 1'b0);
        check("t4_len0_oval", out_valid, 1'b0);
        tick();
        check("t4_len0_pulse", done, 1'b0);
        start_seq(257);
        check("t4_len257_err", err, 1'b1);
        check("t4_len257_busy", busy, 1'b0);
        check("t4_len257_done", done, 1'b0);
        tick();
        check("t4_err_sticky", err, 1'b1);
        fwd_v[0] = 16'h0005; grad_v[0] = 16'h4321; exp_v[0] = 16'h4321;
        start_seq(1);
        check("t4_err_clr", err, 1'b0);
        check("t4_busy", busy, 1'b1);
        capture(1);
        run_back(1, 0, "t4", 1'b1);
        tick();

        // protocol errors
        fwd_valid = 1'b1;
        fwd_data  = 16'h0001;
        tick();
        fwd_valid = 1'b0;
        check("t5_fwd_idle_err", err, 1'b1);
        check("t5_fwd_idle_busy", busy, 1'b0);
        fwd_v[0] = 16'h0003; fwd_v[1] = 16'hFFFD;
        grad_v[0] = 16'h0AAA; grad_v[1] = 16'h0BBB;
        exp_v[0] = 16'h0AAA; exp_v[1] = 16'h0000;
        start_seq(2);
        check("t5_err_clr", err, 1'b0);
        capture(2);
        start_seq(5);
        check("t5_start_bwd_err", err, 1'b1);
        check("t5_start_bwd_busy", busy, 1'b1);
        run_back(2, 0, "t5", 1'b1);
        tick();

        // reset mid-operation
        fwd_v[0] = 16'h0001; fwd_v[1] = 16'h0001; fwd_v[2] = 16'h0001;
        start_seq(3);
        capture(3);
        out_ready  = 1'b0;
        grad_valid = 1'b1;
        grad_data  = 16'h7777;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        grad_valid = 1'b0;
        check("t6_pre_oval", out_valid, 1'b1);
        check("t6_pre_err", err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_oval", out_valid, 1'b0);
        check("t6_odata", out_data, 16'h0);
        check("t6_busy", busy, 1'b0);
        check("t6_err", err, 1'b0);
        check("t6_gready", grad_ready, 1'b0);
        out_ready = 1'b1;
        fwd_v[0] = 16'hFFFB; fwd_v[1] = 16'h0007;
        grad_v[0] = 16'h1234; grad_v[1] = 16'h5678;
        exp_v[0] = 16'h0000; exp_v[1] = 16'h5678;
        start_seq(2);
        capture(2);
        run_back(2, 0, "t6", 1'b1);
        check("t6_err_end", err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
